// File: rtl/noc_local_port_buf_pkg.sv
// Shared NoC flit definitions for the local port buffer: field widths, flit layout and burst-bit helper.
// Also holds the flit width and burst-bit position used by the port and its FIFOs.
package noc_local_port_buf_pkg;

    localparam int NOC_HEADER_SIZE  = 16;
    localparam int NOC_PAYLOAD_SIZE = 32;
    localparam int NOC_FLIT_SIZE    = NOC_HEADER_SIZE + NOC_PAYLOAD_SIZE;
    localparam int NOC_BURST_BIT    = NOC_HEADER_SIZE - 1;

    typedef struct packed {
        logic [NOC_HEADER_SIZE-1:0]  header;
        logic [NOC_PAYLOAD_SIZE-1:0] payload;
    } flit_t;

    // A set burst bit means more flits of the same packet follow.
    function automatic logic is_burst(input flit_t flit);
        return flit.header[NOC_BURST_BIT];
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous first-word-fall-through FIFO; writes are blocked while full, reads while empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module noc_flit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty pointers make stale contents unobservable.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/noc_local_port_buf.sv
// Router-side local NoC port: TX FIFO (interface -> router) and RX FIFO (router -> interface) with burst tracking.
// Optional 32-bit per-direction flit counters are built when NOC_PORT_STATS_EN is defined.
module noc_local_port_buf
    import noc_local_port_buf_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NOC_HEADER_SIZE-1:0]  nif_header_i,
    input  logic [NOC_PAYLOAD_SIZE-1:0] nif_payload_i,
    input  logic                        nif_flit_avail_q_i,
    output logic                        nif_rdreq_o,
    output logic [NOC_HEADER_SIZE-1:0]  rtr_header_o,
    output logic [NOC_PAYLOAD_SIZE-1:0] rtr_payload_o,
    output logic                        rtr_wrreq_o,
    input  logic                        rtr_stall_i,
    input  logic [NOC_HEADER_SIZE-1:0]  rtr_header_i,
    input  logic [NOC_PAYLOAD_SIZE-1:0] rtr_payload_i,
    input  logic                        rtr_wrreq_i,
    output logic                        rtr_stall_o,
    output logic [NOC_HEADER_SIZE-1:0]  nif_header_o,
    output logic [NOC_PAYLOAD_SIZE-1:0] nif_payload_o,
    output logic                        nif_wrreq_o,
    input  logic                        nif_stall_i,
    output logic                        tx_burst_open_o,
    output logic                        rx_burst_open_o
`ifdef NOC_PORT_STATS_EN
    ,
    output logic [31:0]                 tx_flit_cnt_o,
    output logic [31:0]                 rx_flit_cnt_o
`endif
);

    flit_t tx_din, tx_dout, rx_din, rx_dout;
    logic  tx_full, tx_empty, tx_pop;
    logic  rx_full, rx_empty, rx_push, rx_pop;
    logic  tx_burst_open_q, tx_burst_open_d;
    logic  rx_burst_open_q, rx_burst_open_d;

    // TX: pull from the interface whenever it offers a flit and there is room.
    assign nif_rdreq_o   = ~nif_flit_avail_q_i & ~tx_full;
    assign tx_din        = {nif_header_i, nif_payload_i};
    assign rtr_wrreq_o   = ~tx_empty;
    assign tx_pop        = rtr_wrreq_o & ~rtr_stall_i;
    assign rtr_header_o  = tx_dout.header;
    assign rtr_payload_o = tx_dout.payload;

    // RX: a flit offered while stalled is simply not taken; the router keeps it.
    assign rtr_stall_o   = rx_full;
    assign rx_din        = {rtr_header_i, rtr_payload_i};
    assign rx_push       = rtr_wrreq_i & ~rx_full;
    assign nif_wrreq_o   = ~rx_empty;
    assign rx_pop        = nif_wrreq_o & ~nif_stall_i;
    assign nif_header_o  = rx_dout.header;
    assign nif_payload_o = rx_dout.payload;

    noc_flit_fifo #(.DEPTH(TX_DEPTH), .WIDTH(NOC_FLIT_SIZE)) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (nif_rdreq_o),
        .pop_i   (tx_pop),
        .din_i   (tx_din),
        .dout_o  (tx_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    noc_flit_fifo #(.DEPTH(RX_DEPTH), .WIDTH(NOC_FLIT_SIZE)) u_rx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .din_i   (rx_din),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    always_comb begin
        tx_burst_open_d = tx_burst_open_q;
        rx_burst_open_d = rx_burst_open_q;
        if (tx_pop) tx_burst_open_d = is_burst(tx_dout);
        if (rx_pop) rx_burst_open_d = is_burst(rx_dout);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_burst_open_q <= 1'b0;
            rx_burst_open_q <= 1'b0;
        end else begin
            tx_burst_open_q <= tx_burst_open_d;
            rx_burst_open_q <= rx_burst_open_d;
        end
    end

    assign tx_burst_open_o = tx_burst_open_q;
    assign rx_burst_open_o = rx_burst_open_q;

`ifdef NOC_PORT_STATS_EN
    logic [31:0] tx_flit_cnt_q, tx_flit_cnt_d;
    logic [31:0] rx_flit_cnt_q, rx_flit_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        tx_flit_cnt_d = tx_flit_cnt_q;
        rx_flit_cnt_d = rx_flit_cnt_q;
        if (tx_pop) tx_flit_cnt_d = tx_flit_cnt_q + 32'd1;
        if (rx_pop) rx_flit_cnt_d = rx_flit_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_flit_cnt_q <= '0;
            rx_flit_cnt_q <= '0;
        end else begin
            tx_flit_cnt_q <= tx_flit_cnt_d;
            rx_flit_cnt_q <= rx_flit_cnt_d;
        end
    end

    assign tx_flit_cnt_o = tx_flit_cnt_q;
    assign rx_flit_cnt_o = rx_flit_cnt_q;
`endif

endmodule

// File: tb/tb_noc_local_port_buf.sv
// Self-checking bench for noc_local_port_buf: queue-based reference model, directed scenarios and random traffic.
// Counter checks are compiled in when NOC_PORT_STATS_EN is defined.
module tb_noc_local_port_buf;
    import noc_local_port_buf_pkg::*;

    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int H   = NOC_HEADER_SIZE;
    localparam int P   = NOC_PAYLOAD_SIZE;
    localparam int FW  = NOC_FLIT_SIZE;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [H-1:0] nif_header_i, rtr_header_i, rtr_header_o, nif_header_o;
    logic [P-1:0] nif_payload_i, rtr_payload_i, rtr_payload_o, nif_payload_o;
    logic         nif_flit_avail_q_i, nif_rdreq_o, rtr_wrreq_o, rtr_stall_i;
    logic         rtr_wrreq_i, rtr_stall_o, nif_wrreq_o, nif_stall_i;
    logic         tx_burst_open_o, rx_burst_open_o;
`ifdef NOC_PORT_STATS_EN
    logic [31:0]  tx_flit_cnt_o, rx_flit_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    noc_local_port_buf #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .nif_header_i       (nif_header_i),
        .nif_payload_i      (nif_payload_i),
        .nif_flit_avail_q_i (nif_flit_avail_q_i),
        .nif_rdreq_o        (nif_rdreq_o),
        .rtr_header_o       (rtr_header_o),
        .rtr_payload_o      (rtr_payload_o),
        .rtr_wrreq_o        (rtr_wrreq_o),
        .rtr_stall_i        (rtr_stall_i),
        .rtr_header_i       (rtr_header_i),
        .rtr_payload_i      (rtr_payload_i),
        .rtr_wrreq_i        (rtr_wrreq_i),
        .rtr_stall_o        (rtr_stall_o),
        .nif_header_o       (nif_header_o),
        .nif_payload_o      (nif_payload_o),
        .nif_wrreq_o        (nif_wrreq_o),
        .nif_stall_i        (nif_stall_i),
        .tx_burst_open_o    (tx_burst_open_o),
        .rx_burst_open_o    (rx_burst_open_o)
`ifdef NOC_PORT_STATS_EN
        ,
        .tx_flit_cnt_o      (tx_flit_cnt_o),
        .rx_flit_cnt_o      (rx_flit_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each direction is an ordered queue bounded by its depth.
    logic [FW-1:0] tx_q[$];
    logic [FW-1:0] rx_q[$];
    bit            m_tx_burst, m_rx_burst, m_rx_acc;
    int unsigned   m_tx_cnt, m_rx_cnt;

    // One clock: compare DUT outputs to the model mid-cycle, then advance the model at the edge.
    task automatic step();
        bit tx_push, tx_pop, rx_push, rx_pop;
        logic [FW-1:0] f;
        @(negedge clk_i);
        check("nif_rdreq", nif_rdreq_o, !nif_flit_avail_q_i && tx_q.size() < TXD);
        check("rtr_wrreq", rtr_wrreq_o, tx_q.size() != 0);
        if (tx_q.size() != 0) check("rtr_flit", {rtr_header_o, rtr_payload_o}, tx_q[0]);
        check("rtr_stall_o", rtr_stall_o, rx_q.size() == RXD);
        check("nif_wrreq", nif_wrreq_o, rx_q.size() != 0);
        if (rx_q.size() != 0) check("nif_flit", {nif_header_o, nif_payload_o}, rx_q[0]);
        check("tx_burst_open", tx_burst_open_o, m_tx_burst);
        check("rx_burst_open", rx_burst_open_o, m_rx_burst);
`ifdef NOC_PORT_STATS_EN
        check("tx_flit_cnt", tx_flit_cnt_o, m_tx_cnt);
        check("rx_flit_cnt", rx_flit_cnt_o, m_rx_cnt);
`endif
        @(posedge clk_i);
        m_rx_acc = 0;
        if (reset_i) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_burst = 0;
            m_rx_burst = 0;
            m_tx_cnt   = 0;
            m_rx_cnt   = 0;
        end else begin
            tx_push = !nif_flit_avail_q_i && tx_q.size() < TXD;
            tx_pop  = tx_q.size() != 0 && !rtr_stall_i;
            rx_push = rtr_wrreq_i && rx_q.size() < RXD;
            rx_pop  = rx_q.size() != 0 && !nif_stall_i;
            if (tx_pop) begin
                f = tx_q.pop_front();
                m_tx_burst = f[FW-1];
                m_tx_cnt++;
            end
            if (rx_pop) begin
                f = rx_q.pop_front();
                m_rx_burst = f[FW-1];
                m_rx_cnt++;
            end
            if (tx_push) tx_q.push_back({nif_header_i, nif_payload_i});
            if (rx_push) rx_q.push_back({rtr_header_i, rtr_payload_i});
            m_rx_acc = rx_push;
        end
        #1;
    endtask

    task automatic idle_inputs();
        nif_header_i       = '0;
        nif_payload_i      = '0;
        nif_flit_avail_q_i = 1'b1;
        rtr_stall_i        = 1'b0;
        rtr_header_i       = '0;
        rtr_payload_i      = '0;
        rtr_wrreq_i        = 1'b0;
        nif_stall_i        = 1'b0;
    endtask

    int k;
    int rdreq_pulses;
    logic [P-1:0] got_q[$];

    initial begin
        idle_inputs();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        #1;
        check("reset_rtr_wrreq", rtr_wrreq_o, 1'b0);
        check("reset_nif_wrreq", nif_wrreq_o, 1'b0);
        check("reset_rtr_stall", rtr_stall_o, 1'b0);
        check("reset_bursts", {tx_burst_open_o, rx_burst_open_o}, 2'b00);
        step();

        // Single TX flit, non-burst header.
        nif_flit_avail_q_i = 1'b0;
        nif_header_i       = 16'h0012;
        nif_payload_i      = 32'h0000_00A5;
        #1;
        check("single_rdreq", nif_rdreq_o, 1'b1);
        step();
        nif_flit_avail_q_i = 1'b1;
        #1;
        check("single_wrreq", rtr_wrreq_o, 1'b1);
        check("single_payload", rtr_payload_o, 32'h0000_00A5);
        step();
        check("single_burst", tx_burst_open_o, 1'b0);
        check("single_drained", rtr_wrreq_o, 1'b0);

        // TX fill under router stall, then drain in order.
        rtr_stall_i        = 1'b1;
        nif_flit_avail_q_i = 1'b0;
        rdreq_pulses       = 0;
        for (int i = 0; i < 8; i++) begin
            nif_payload_i = 32'h100 + i;
            #1;
            if (nif_rdreq_o) rdreq_pulses++;
            step();
        end
        check("fill_rdreq_pulses", rdreq_pulses, TXD);
        check("fill_rdreq_low", nif_rdreq_o, 1'b0);
        nif_flit_avail_q_i = 1'b1;
        rtr_stall_i        = 1'b0;
        for (int i = 0; i < TXD; i++) begin
            #1;
            check("drain_payload", rtr_payload_o, 32'h100 + i);
            step();
        end
        check("drain_empty", rtr_wrreq_o, 1'b0);

        // RX full boundary: router presents flits 1..5 while interface stalls.
        nif_stall_i = 1'b1;
        k = 1;
        for (int i = 0; i < 6; i++) begin
            rtr_wrreq_i   = 1'b1;
            rtr_header_i  = '0;
            rtr_payload_i = k;
            step();
            if (m_rx_acc) k++;
        end
        check("rx_accepted", k - 1, RXD);
        check("rx_stall_full", rtr_stall_o, 1'b1);
        nif_stall_i = 1'b0;
        got_q.delete();
        for (int i = 0; i < 20 && got_q.size() < 5; i++) begin
            rtr_wrreq_i   = (k <= 5);
            rtr_payload_i = k;
            #1;
            if (nif_wrreq_o && !nif_stall_i) got_q.push_back(nif_payload_o);
            step();
            if (m_rx_acc) k++;
        end
        rtr_wrreq_i = 1'b0;
        check("rx_order_count", got_q.size(), 5);
        for (int i = 0; i < got_q.size(); i++) check("rx_order", got_q[i], i + 1);

        // RX burst of three: MSBs 1,1,0.
        nif_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rtr_wrreq_i   = 1'b1;
            rtr_header_i  = (i < 2) ? 16'h8001 : 16'h0001;
            rtr_payload_i = 32'h200 + i;
            step();
        end
        rtr_wrreq_i = 1'b0;
        check("burst_pre", rx_burst_open_o, 1'b0);
        nif_stall_i = 1'b0;
        step();
        check("burst_first", rx_burst_open_o, 1'b1);
        step();
        check("burst_second", rx_burst_open_o, 1'b1);
        step();
        check("burst_last", rx_burst_open_o, 1'b0);

        // Reset in the middle of a TX burst with flits still queued.
        rtr_stall_i        = 1'b1;
        nif_flit_avail_q_i = 1'b0;
        nif_header_i       = 16'h8003;
        for (int i = 0; i < 3; i++) begin
            nif_payload_i = 32'h300 + i;
            step();
        end
        nif_flit_avail_q_i = 1'b1;
        rtr_stall_i        = 1'b0;
        step();
        rtr_stall_i = 1'b1;
        step();
        check("midburst_open", tx_burst_open_o, 1'b1);
        check("midburst_queued", rtr_wrreq_o, 1'b1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("rst_rtr_wrreq", rtr_wrreq_o, 1'b0);
        check("rst_nif_wrreq", nif_wrreq_o, 1'b0);
        check("rst_nif_rdreq", nif_rdreq_o, 1'b0);
        check("rst_bursts", {tx_burst_open_o, rx_burst_open_o}, 2'b00);
        check("rst_rtr_stall", rtr_stall_o, 1'b0);
        step();
        check("rst_still_empty", rtr_wrreq_o, 1'b0);

        // Random traffic in both directions with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset_i            = ($urandom_range(0, 499) == 0);
            nif_flit_avail_q_i = $urandom_range(0, 1);
            nif_header_i       = H'($urandom);
            nif_payload_i      = $urandom;
            rtr_stall_i        = ($urandom_range(0, 2) == 0);
            rtr_wrreq_i        = $urandom_range(0, 1);
            rtr_header_i       = H'($urandom);
            rtr_payload_i      = $urandom;
            nif_stall_i        = ($urandom_range(0, 2) == 0);
            step();
        end
        reset_i = 1'b0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
